// File: rtl/image_link_pkg.sv
// Shared types and widths for the UART pixel link receiver.
package image_link_pkg;

    localparam int PIXEL_W = 12;
    localparam int ADDR_W  = 17;

    // A valid first byte of a pixel carries only the red nibble in its low half.
    localparam logic [7:0] HI_NIBBLE_MASK = 8'hF0;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {HI, LO} asm_phase_t;

endpackage

// File: rtl/image_receiver_if.sv
// Frame-buffer write bus of the pixel receiver, plus the FSM states for observation.
interface image_receiver_if;
    import image_link_pkg::*;

    logic [ADDR_W-1:0]  wr_addr;
    logic [PIXEL_W-1:0] wr_data;
    logic               wr_en;
    logic               image_done;
    rx_state_t          rx_state;
    asm_phase_t         phase;

    // Handshake: wr_en is a one-cycle strobe with no back-pressure; wr_addr/wr_data
    // are valid in the wr_en cycle and hold their last value otherwise.
    modport master (output wr_addr, wr_data, wr_en, image_done, rx_state, phase);
    modport slave  (input  wr_addr, wr_data, wr_en, image_done, rx_state, phase);

endinterface

// File: rtl/image_receiver_uart_rx.sv
// 8N1 UART byte receiver (module uart_rx_byte): 2-FF input synchroniser and RX FSM.
module uart_rx_byte
    import image_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_error,
    output logic       busy,
    output rx_state_t  state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1, line;
    rx_state_t        state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             hold, hold_n;
    logic             valid_n, serr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            line       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            hold       <= 1'b0;
            byte_valid <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            sync1      <= uart_in;
            line       <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            hold       <= hold_n;
            byte_valid <= valid_n;
            stop_error <= serr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        hold_n    = hold;
        valid_n   = 1'b0;
        serr_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                // After a bad stop bit the line must go high again before a new start counts.
                if (hold) begin
                    if (line) hold_n = 1'b0;
                end else if (!line) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    shift_n   = {line, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (line) begin
                        valid_n = 1'b1;
                    end else begin
                        serr_n = 1'b1;
                        hold_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign byte_data = shift;
    assign busy      = (state == DATA) || (state == STOP);

endmodule

// File: rtl/image_receiver.sv
// Pixel receiver top: pairs UART bytes into 12-bit pixels and writes them to a frame buffer.
// Optional inter-byte timeout in phase LO is enabled by defining IMAGE_RX_TIMEOUT_EN.
module image_receiver
    import image_link_pkg::*;
#(
    parameter int NUM_PIXELS   = 100,
    parameter int CLKS_PER_BIT = 50_000_000 / 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_in,
    image_receiver_if.master         fb,
    output logic                     frame_error,
    output logic                     busy
);

    logic [7:0]         byte_data;
    logic               byte_valid, stop_error;
    rx_state_t          rx_state;

    asm_phase_t         phase, phase_n;
    logic [3:0]         nib, nib_n;
    logic [ADDR_W-1:0]  idx, idx_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [PIXEL_W-1:0] data_q, data_n;
    logic               wr_en_q, wr_en_n;
    logic               done_q, done_n;
    logic               ferr_q, ferr_n;
    logic               tmo_hit;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .stop_error (stop_error),
        .busy       (busy),
        .state      (rx_state)
    );

`ifdef IMAGE_RX_TIMEOUT_EN
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    logic [31:0] tmo;

    always_ff @(posedge clk) begin
        if (rst || phase != LO || byte_valid) tmo <= '0;
        else                                  tmo <= tmo + 32'd1;
    end

    assign tmo_hit = (phase == LO) && (tmo == TMO_LIMIT - 1);
`else
    logic [31:0] tmo_unused;
    assign tmo_unused = 32'(TIMEOUT_BITS);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= HI;
            nib     <= '0;
            idx     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            phase   <= phase_n;
            nib     <= nib_n;
            idx     <= idx_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            wr_en_q <= wr_en_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        phase_n = phase;
        nib_n   = nib;
        idx_n   = idx;
        addr_n  = addr_q;
        data_n  = data_q;
        wr_en_n = 1'b0;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        if (stop_error) begin
            // A lost byte drops any half-built pixel; the index is left alone.
            ferr_n  = 1'b1;
            phase_n = HI;
        end else if (byte_valid) begin
            if (phase == HI) begin
                if ((byte_data & HI_NIBBLE_MASK) != 8'h00) begin
                    ferr_n = 1'b1;
                end else begin
                    nib_n   = byte_data[3:0];
                    phase_n = LO;
                end
            end else begin
                wr_en_n = 1'b1;
                data_n  = {nib, byte_data};
                addr_n  = idx;
                phase_n = HI;
                if (idx == ADDR_W'(NUM_PIXELS - 1)) begin
                    done_n = 1'b1;
                    idx_n  = '0;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end else if (tmo_hit) begin
            ferr_n  = 1'b1;
            phase_n = HI;
        end
    end

    assign fb.wr_addr    = addr_q;
    assign fb.wr_data    = data_q;
    assign fb.wr_en      = wr_en_q;
    assign fb.image_done = done_q;
    assign fb.rx_state   = rx_state;
    assign fb.phase      = phase;
    assign frame_error   = ferr_q;

endmodule

// File: tb/tb_image_receiver.sv
// Self-checking bench for image_receiver: table-driven pixel stream plus hand-written corner sequences.
module tb_image_receiver;
    import image_link_pkg::*;

    localparam int CPB = 8;
    localparam int NP  = 4;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [16:0] addr;
        logic [11:0] data;
        logic        done;
    } vec_t;

    logic clk, rst, uart_in, frame_error, busy;
    image_receiver_if fb();

    image_receiver #(.NUM_PIXELS(NP), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .fb          (fb),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int ferr_cnt = 0;
    int f0;
    logic prev_busy = 1'b0;
    logic busy_seen = 1'b0;
    logic [29:0] exp_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // driver tasks; callers are aligned to a falling edge
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_in = 1'b1;
    endtask

    task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [16:0] addr, input logic done);
        exp_q.push_back({done, addr, b0[3:0], b1});
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard / monitor
    task automatic monitor();
        logic [29:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_error) ferr_cnt++;
            if (busy) busy_seen = 1'b1;
            if (prev_busy && !busy) fall_cyc = cyc;
            prev_busy = busy;
            if (fb.image_done && !fb.wr_en) begin
                checks++;
                errors++;
                $display("FAIL done_without_wr: image_done=1 with wr_en=0 at cycle %0d", cyc);
            end
            if (fb.wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h, no write expected", fb.wr_addr, fb.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(fb.wr_addr), 32'(e[28:12]));
                    chk("wr_data", 32'(fb.wr_data), 32'(e[11:0]));
                    chk("image_done", 32'(fb.image_done), 32'(e[29]));
                    chk("latency_after_busy_fall", 32'(cyc - fall_cyc), 32'd1);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        vecs[0] = '{b0: 8'h00, b1: 8'h01, addr: 17'd0, data: 12'h001, done: 1'b0};
        vecs[1] = '{b0: 8'h00, b1: 8'h02, addr: 17'd1, data: 12'h002, done: 1'b0};
        vecs[2] = '{b0: 8'h00, b1: 8'h03, addr: 17'd2, data: 12'h003, done: 1'b0};
        vecs[3] = '{b0: 8'h00, b1: 8'h04, addr: 17'd3, data: 12'h004, done: 1'b1};
        vecs[4] = '{b0: 8'h00, b1: 8'h05, addr: 17'd0, data: 12'h005, done: 1'b0};

        // reset state
        rst = 1'b1;
        uart_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_addr", 32'(fb.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(fb.wr_data), 32'd0);
        chk("rst_wr_en", 32'(fb.wr_en), 32'd0);
        chk("rst_image_done", 32'(fb.image_done), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_state", 32'(fb.rx_state), 32'(IDLE));
        chk("rst_phase", 32'(fb.phase), 32'(HI));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single pixel
        f0 = ferr_cnt;
        send_pixel(8'h0A, 8'hBC, 17'd0, 1'b0);
        wait_drain("single_drain");
        chk("single_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // full image with wrap, back to back from a fresh reset
        pulse_rst();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({vecs[i].done, vecs[i].addr, vecs[i].data});
            send_byte(vecs[i].b0, 1'b1);
            send_byte(vecs[i].b1, 1'b1);
        end
        wait_drain("wrap_drain");

        // bad stop bit on byte1, then a good pair at the unchanged index
        f0 = ferr_cnt;
        send_byte(8'h03, 1'b1);
        send_byte(8'h45, 1'b0);
        repeat (20) @(negedge clk);
        chk("bad_stop_ferr", 32'(ferr_cnt - f0), 32'd1);
        send_pixel(8'h01, 8'h23, 17'd1, 1'b0);
        wait_drain("bad_stop_drain");

        // bad high byte, then resync
        f0 = ferr_cnt;
        send_byte(8'h5F, 1'b1);
        repeat (10) @(negedge clk);
        chk("bad_hi_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("bad_hi_phase", 32'(fb.phase), 32'(HI));
        send_pixel(8'h0F, 8'hFF, 17'd2, 1'b0);
        wait_drain("bad_hi_drain");

        // 2-cycle glitch is rejected silently
        f0 = ferr_cnt;
        busy_seen = 1'b0;
        uart_in = 1'b0;
        repeat (2) @(negedge clk);
        uart_in = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy", 32'(busy_seen), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // reset in the middle of byte1's data bits
        send_byte(8'h0A, 1'b1);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_in = ~uart_in;
            repeat (CPB) @(negedge clk);
        end
        chk("mid_byte_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        uart_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_wr_addr", 32'(fb.wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(fb.wr_data), 32'd0);
        chk("mid_rst_wr_en", 32'(fb.wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ferr", 32'(frame_error), 32'd0);
        chk("mid_rst_phase", 32'(fb.phase), 32'(HI));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_pixel(8'h01, 8'h55, 17'd0, 1'b0);
        wait_drain("post_rst_drain");

`ifdef IMAGE_RX_TIMEOUT_EN
        // inter-byte timeout in phase LO
        f0 = ferr_cnt;
        send_byte(8'h0A, 1'b1);
        repeat (170) @(negedge clk);
        chk("timeout_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("timeout_phase", 32'(fb.phase), 32'(HI));
        send_pixel(8'h01, 8'h02, 17'd1, 1'b0);
        wait_drain("timeout_drain");
`endif

        repeat (10) @(negedge clk);
        wait_drain("final_drain");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- UART receive end of the pixel link: deserialises 8N1 bytes, pairs them into 12-bit pixels, and writes each pixel into a frame buffer.
- Mirrors the FPGA pixel transmitter. It is used in loopback verification and on the receiving board to rebuild a NUM_PIXELS image at consecutive addresses from 0.

Parameters:
- NUM_PIXELS, 100: pixels per image. Write address wraps to 0 after NUM_PIXELS-1.
- CLKS_PER_BIT, 50_000_000/9600: clk cycles per UART bit. Must be at least 4.
- TIMEOUT_BITS, 20: inter-byte gap limit, in bit periods (used only with IMAGE_RX_TIMEOUT_EN).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- uart_in, input, 1: asynchronous serial line. Idles high.
- wr_addr, output, 17: frame-buffer write address.
- wr_data, output, 12: pixel value, {R[3:0],G[3:0],B[3:0]}.
- wr_en, output, 1: one-cycle write strobe.
- image_done, output, 1: one-cycle pulse, coincident with the wr_en for address NUM_PIXELS-1.
- frame_error, output, 1: one-cycle pulse on a bad stop bit or a bad high byte.
- busy, output, 1: high from detection of a valid start bit until the stop bit is sampled.

Behaviour:
- Clock and reset:
  - One clock domain, clk. Reset is synchronous and active-high on rst.
  - Reset values: wr_addr=0, wr_data=0, wr_en=0, image_done=0, frame_error=0, busy=0.
  - Reset places the RX FSM in IDLE and the assembler in phase HI.
  - rst mid-byte or mid-pixel aborts that byte/pixel with no write.
- Input synchronisation: uart_in passes through a 2-FF synchroniser, reset value 1. All sampling uses the synchronised value.
- RX FSM, 8N1, LSB first:
  - IDLE: the first cycle the synced line is 0 → START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1, line still 0 → DATA with busy=1. Line 1 → IDLE (glitch rejected, no error).
  - DATA: sample one bit every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first → STOP.
  - STOP: sample after CLKS_PER_BIT.
    - Line 1: byte_valid pulses for one cycle.
    - Line 0: frame_error pulses, the byte is discarded, and the FSM waits in IDLE for the line to return to 1 before accepting a new start.
  - busy drops in the cycle the stop bit is sampled.
- Pixel assembler (phase HI/LO):
  - Wire format per pixel: byte0 = {4'b0000, pixel[11:8]}, then byte1 = pixel[7:0].
  - HI: on byte_valid, upper nibble 0 → latch nibble, go to LO. Upper nibble nonzero → frame_error pulse, stay HI (resync).
  - LO: on byte_valid → write pixel, go to HI.
- Write timing:
  - wr_en is asserted the cycle after byte_valid of byte1, with wr_data={nibble,byte1} and wr_addr = current pixel index.
  - Pixel index increments after each write. At NUM_PIXELS-1, image_done=1 in the same cycle as wr_en, and the index returns to 0.
  - wr_addr and wr_data hold their last values when wr_en=0.
- Framing error during phase LO: the assembler returns to HI, the pixel is dropped, and the index is unchanged.
- Latency: from the stop-bit sample of byte1 to wr_en is 2 cycles.
- Back-to-back bytes with no idle gap must be received without loss.

Optional Feature:
- Macro: IMAGE_RX_TIMEOUT_EN.
- Defined:
  - A counter runs while the assembler is in phase LO.
  - If TIMEOUT_BITS*CLKS_PER_BIT cycles pass without a byte_valid, the assembler returns to HI, frame_error pulses once, and the index is unchanged.
  - The counter clears on every byte_valid.
- Undefined: no timer; the assembler waits in LO indefinitely.

Decomposition:
- Package image_link_pkg:
  - PIXEL_W=12, ADDR_W=17.
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - asm_phase_t enum {HI, LO}.
  - HI_NIBBLE_MASK=8'hF0.
- Sub-module uart_rx_byte:
  - Contains the synchroniser and RX FSM.
  - Outputs: byte_data[7:0], byte_valid, stop_error, busy.
- image_receiver contains the assembler, address counter, and timeout logic.

Test Plan:
- Bench settings: CLKS_PER_BIT=8, NUM_PIXELS=4.
- Single pixel: send 0x0A then 0xBC → one wr_en with wr_data=12'hABC, wr_addr=0, 2 cycles after byte1's stop sample. No frame_error.
- Full image with wrap:
  - Send 5 pixels, 0x001..0x005, back to back → writes at addresses 0,1,2,3,0.
  - image_done pulses only with the address-3 write.
- Bad stop bit: byte0 0x03 is good; byte1 is sent with stop=0 → frame_error pulse, no wr_en.
  - Next pair 0x01,0x23 → write 0x123 at the unchanged index.
- Bad high byte: send 0x5F → frame_error, stays in HI. Then 0x0F,0xFF → write 0xFFF.
- Glitch and reset:
  - A 2-cycle low pulse on uart_in gives no busy and no error.
  - rst asserted during DATA of byte1 → outputs at reset values.
  - A following pair writes at address 0.
- Timeout (IMAGE_RX_TIMEOUT_EN, TIMEOUT_BITS=20): send 0x0A, idle 161 cycles → frame_error.
  - Then 0x01,0x02 → write 0x102.
